pe_out_collector: RTL and testbench

Receive-side endpoint for the bottom row of the PE mesh. It accepts each column's valid-only result stream and converts it into a ready/valid stream for the accumulator/writeback path. The PE side has no backpressure, so the block buffers results in a FIFO. It exports a free-slot count so the issue controller can throttle, and it tracks tile boundaries using the `last` flag.

---
 rtl/pe_collector_pkg.sv | 15 +
 rtl/pe_collector_fifo.sv | 60 ++++++
 rtl/pe_out_collector.sv | 160 ++++++++++++++++
 tb/tb_pe_out_collector.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_collector_pkg.sv
// Shared widths and the buffered result record for the PE mesh output collector.
package pe_collector_pkg;

  localparam int unsigned D_WIDTH    = 20;
  localparam int unsigned ID_WIDTH   = 3;
  localparam int unsigned ROWS_WIDTH = 8;

  typedef struct packed {
    logic [D_WIDTH-1:0]  d;
    logic [ID_WIDTH-1:0] id;
    logic                last;
    logic                propagate;
  } pe_result_t;

endpackage

// File: rtl/pe_collector_fifo.sv
// Synchronous FIFO of PE results. Pointers wrap modulo DEPTH; count is kept
// separately (0..DEPTH). The caller never pops when empty and only pushes
// into a full FIFO together with a pop.
module pe_collector_fifo import pe_collector_pkg::*; #(
  parameter int unsigned DEPTH = 8,
  parameter type entry_t = pe_result_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;

  // Storage array: written on push only, no reset needed (egress is gated).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/pe_out_collector.sv
// Bottom-row PE mesh collector: buffers the valid-only PE result stream into a
// FIFO and presents it as a ready/valid stream, with free-slot reporting,
// per-tile row counting and sticky overflow / dataflow-error flags.
// Optional feature macro: PE_COLLECTOR_BAD_DATAFLOW_EN (drop and flag inputs
// carrying bad_dataflow; when undefined the flag input is ignored).
module pe_out_collector #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned D_WIDTH    = pe_collector_pkg::D_WIDTH,
  parameter int unsigned ID_WIDTH   = pe_collector_pkg::ID_WIDTH,
  parameter int unsigned ROWS_WIDTH = pe_collector_pkg::ROWS_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_input_payload_discriminant,
  input  logic [D_WIDTH-1:0]      in_input_payload_Some_0_d,
  input  logic [ID_WIDTH-1:0]     in_input_payload_Some_0_id,
  input  logic                    in_input_payload_Some_0_last,
  input  logic                    in_input_payload_Some_0_control_propagate_discriminant,
  input  logic                    in_input_payload_Some_0_bad_dataflow,
  output logic                    out_output_payload_discriminant,
  output logic [D_WIDTH-1:0]      out_output_payload_Some_0_d,
  output logic [ID_WIDTH-1:0]     out_output_payload_Some_0_id,
  output logic                    out_output_payload_Some_0_last,
  output logic                    out_output_payload_Some_0_propagate,
  input  logic                    out_output_resolver_ready,
  output logic [$clog2(DEPTH):0]  out_free_slots,
  output logic                    out_tile_done,
  output logic [ID_WIDTH-1:0]     out_tile_done_id,
  output logic [ROWS_WIDTH-1:0]   out_tile_rows,
  output logic                    out_overflow,
  output logic                    out_bad_dataflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [D_WIDTH-1:0]  d;
    logic [ID_WIDTH-1:0] id;
    logic                last;
    logic                propagate;
  } entry_t;

  entry_t             wdata;
  entry_t             head;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_next;
  logic               in_valid;
  logic               blocked;
  logic               push;
  logic               pop;
  logic               egress_valid;
  logic [ROWS_WIDTH-1:0] rows_cnt;
  logic [ROWS_WIDTH-1:0] rows_inc;
  logic               overflow_q;
  logic               bad_q;
  logic [CNT_W-1:0]   free_q;
  logic               tile_done_q;
  logic [ID_WIDTH-1:0]   tile_id_q;
  logic [ROWS_WIDTH-1:0] tile_rows_q;

  assign in_valid = in_input_payload_discriminant;
  assign wdata    = '{d:         in_input_payload_Some_0_d,
                      id:        in_input_payload_Some_0_id,
                      last:      in_input_payload_Some_0_last,
                      propagate: in_input_payload_Some_0_control_propagate_discriminant};

`ifdef PE_COLLECTOR_BAD_DATAFLOW_EN
  assign blocked = in_valid & in_input_payload_Some_0_bad_dataflow;
`else
  logic unused_bad_dataflow;
  assign unused_bad_dataflow = in_input_payload_Some_0_bad_dataflow;
  assign blocked = 1'b0;
`endif

  // Egress valid only depends on stored state, so push-at-empty never pops.
  assign egress_valid = ~empty;
  assign pop          = egress_valid & out_output_resolver_ready;
  assign push         = in_valid & ~blocked & ~rst & (~full | pop);

  pe_collector_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Occupancy after this cycle's push/pop, used for the registered free count.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = fifo_count - CNT_W'(1);
    end
  end

  assign rows_inc = (rows_cnt == {ROWS_WIDTH{1'b1}}) ? rows_cnt : rows_cnt + ROWS_WIDTH'(1);

  // Free-slot report and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_q     <= CNT_W'(DEPTH);
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      free_q <= CNT_W'(DEPTH) - count_next;
      if (in_valid && !blocked && full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (blocked) begin
        bad_q <= 1'b1;
      end
    end
  end

  // Row counter and tile-completion register; a last=1 pop closes the tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_cnt    <= '0;
      tile_done_q <= 1'b0;
      tile_id_q   <= '0;
      tile_rows_q <= '0;
    end else begin
      tile_done_q <= 1'b0;
      if (pop) begin
        if (head.last) begin
          tile_done_q <= 1'b1;
          tile_id_q   <= head.id;
          tile_rows_q <= rows_inc;
          rows_cnt    <= '0;
        end else begin
          rows_cnt <= rows_inc;
        end
      end
    end
  end

  assign out_output_payload_discriminant     = egress_valid;
  assign out_output_payload_Some_0_d         = egress_valid ? head.d : '0;
  assign out_output_payload_Some_0_id        = egress_valid ? head.id : '0;
  assign out_output_payload_Some_0_last      = egress_valid & head.last;
  assign out_output_payload_Some_0_propagate = egress_valid & head.propagate;
  assign out_free_slots                      = free_q;
  assign out_tile_done                       = tile_done_q;
  assign out_tile_done_id                    = tile_id_q;
  assign out_tile_rows                       = tile_rows_q;
  assign out_overflow                        = overflow_q;
  assign out_bad_dataflow                    = bad_q;

endmodule

// File: tb/tb_pe_out_collector.sv
// Directed bench for pe_out_collector (DEPTH=8, D=20, ID=3, ROWS=8).
module tb_pe_out_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [19:0] in_d;
  logic [2:0]  in_id;
  logic        in_last;
  logic        in_prop;
  logic        in_bad;
  logic        out_valid;
  logic [19:0] out_d;
  logic [2:0]  out_id;
  logic        out_last;
  logic        out_prop;
  logic        ready;
  logic [3:0]  free_slots;
  logic        tile_done;
  logic [2:0]  tile_id;
  logic [7:0]  tile_rows;
  logic        overflow;
  logic        bad_flag;

  int n_checks = 0;
  int n_errors = 0;

  pe_out_collector dut (
    .clk                                                    (clk),
    .rst                                                    (rst),
    .in_input_payload_discriminant                          (in_valid),
    .in_input_payload_Some_0_d                              (in_d),
    .in_input_payload_Some_0_id                             (in_id),
    .in_input_payload_Some_0_last                           (in_last),
    .in_input_payload_Some_0_control_propagate_discriminant (in_prop),
    .in_input_payload_Some_0_bad_dataflow                   (in_bad),
    .out_output_payload_discriminant                        (out_valid),
    .out_output_payload_Some_0_d                            (out_d),
    .out_output_payload_Some_0_id                           (out_id),
    .out_output_payload_Some_0_last                         (out_last),
    .out_output_payload_Some_0_propagate                    (out_prop),
    .out_output_resolver_ready                              (ready),
    .out_free_slots                                         (free_slots),
    .out_tile_done                                          (tile_done),
    .out_tile_done_id                                       (tile_id),
    .out_tile_rows                                          (tile_rows),
    .out_overflow                                           (overflow),
    .out_bad_dataflow                                       (bad_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [19:0] d, input logic [2:0] id,
                       input logic last, input logic prop, input logic bad);
    in_valid = v;
    in_d     = d;
    in_id    = id;
    in_last  = last;
    in_prop  = prop;
    in_bad   = bad;
  endtask

  task automatic idle();
    drive(1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [19:0] q[$];
  int          pops;
  logic        hs;

  initial begin
    rst   = 1'b1;
    ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid",     32'(out_valid),  32'd0);
    check("rst_data",      32'(out_d),      32'd0);
    check("rst_free",      32'(free_slots), 32'd8);
    check("rst_tile_done", 32'(tile_done),  32'd0);
    check("rst_tile_id",   32'(tile_id),    32'd0);
    check("rst_tile_rows", 32'(tile_rows),  32'd0);
    check("rst_overflow",  32'(overflow),   32'd0);
    check("rst_bad",       32'(bad_flag),   32'd0);

    // Single entry, 1-cycle latency, free 8->7->8
    ready = 1'b1;
    drive(1'b1, 20'h12345, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    check("single_valid", 32'(out_valid),  32'd1);
    check("single_d",     32'(out_d),      32'h12345);
    check("single_id",    32'(out_id),     32'd2);
    check("single_last",  32'(out_last),   32'd0);
    check("single_prop",  32'(out_prop),   32'd1);
    check("single_free7", 32'(free_slots), 32'd7);
    tick();
    check("single_drain_valid", 32'(out_valid),  32'd0);
    check("single_gated_d",     32'(out_d),      32'd0);
    check("single_free8",       32'(free_slots), 32'd8);

    // Fill to full, then concurrent push+pop at full, then a drop
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 20'(256 + i), 3'd1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    check("full_free0",    32'(free_slots), 32'd0);
    check("full_no_ovf",   32'(overflow),   32'd0);
    ready = 1'b1;
    drive(1'b1, 20'h200, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    ready = 1'b0;
    idle();
    check("pushpop_free0",  32'(free_slots), 32'd0);
    check("pushpop_no_ovf", 32'(overflow),   32'd0);
    check("pushpop_head",   32'(out_d),      32'h101);
    drive(1'b1, 20'h2FF, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    check("drop_ovf",  32'(overflow),   32'd1);
    check("drop_free", 32'(free_slots), 32'd0);
    check("drop_head", 32'(out_d),      32'h101);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_d", 32'(out_d), (i < 7) ? 32'(257 + i) : 32'h200);
      tick();
    end
    check("drain_empty", 32'(out_valid),  32'd0);
    check("drain_free",  32'(free_slots), 32'd8);
    check("ovf_sticky",  32'(overflow),   32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_ovf", 32'(overflow), 32'd0);

    // Tile of 4 rows, id 5
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 20'(1024 + i), 3'd5, (i == 3), 1'b0, 1'b0);
      tick();
    end
    idle();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tile_no_pulse", 32'(tile_done), 32'd0);
      check("tile_d",        32'(out_d),     32'(1024 + i));
      tick();
    end
    check("tile_done",  32'(tile_done),  32'd1);
    check("tile_id",    32'(tile_id),    32'd5);
    check("tile_rows4", 32'(tile_rows),  32'd4);
    tick();
    check("tile_pulse_1cyc", 32'(tile_done), 32'd0);
    check("tile_id_hold",    32'(tile_id),   32'd5);
    check("tile_rows_hold",  32'(tile_rows), 32'd4);

    // Counter restarted: 2-row tile id 6, streamed with ready=1
    drive(1'b1, 20'h500, 3'd6, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 20'h501, 3'd6, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check("tile2_done", 32'(tile_done), 32'd1);
    check("tile2_id",   32'(tile_id),   32'd6);
    check("tile2_rows", 32'(tile_rows), 32'd2);

    // Back-to-back last pops
    ready = 1'b0;
    drive(1'b1, 20'h600, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 20'h601, 3'd4, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    ready = 1'b1;
    tick();
    check("b2b_done0", 32'(tile_done), 32'd1);
    check("b2b_id0",   32'(tile_id),   32'd3);
    check("b2b_rows0", 32'(tile_rows), 32'd1);
    tick();
    check("b2b_done1", 32'(tile_done), 32'd1);
    check("b2b_id1",   32'(tile_id),   32'd4);
    check("b2b_rows1", 32'(tile_rows), 32'd1);
    tick();
    check("b2b_end",   32'(tile_done), 32'd0);

    // Stalled egress: ready toggles 1,0,1,0 during a 6-entry burst
    pops = 0;
    for (int c = 0; c < 16; c++) begin
      ready = (c < 4) ? ((c % 2) == 0) : 1'b1;
      if (c < 6) drive(1'b1, 20'(1792 + c), 3'd1, 1'b0, 1'b0, 1'b0);
      else       idle();
      check("stall_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("stall_d", 32'(out_d), 32'(q[0]));
      hs = (q.size() != 0) && ready;
      tick();
      if (hs) begin
        void'(q.pop_front());
        pops++;
      end
      if (c < 6) q.push_back(20'(1792 + c));
    end
    check("stall_pops",  32'(pops),       32'd6);
    check("stall_empty", 32'(out_valid),  32'd0);
    check("stall_free",  32'(free_slots), 32'd8);

    // Reset mid-burst: partial tile count of 2, FIFO full, overflow set
    ready = 1'b1;
    drive(1'b1, 20'h800, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 20'h801, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 20'(2304 + i), 3'd1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("mid_ovf_set", 32'(overflow),   32'd1);
    check("mid_full",    32'(free_slots), 32'd0);
    rst = 1'b1;
    drive(1'b1, 20'hAAA, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    check("mid_rst_valid", 32'(out_valid),  32'd0);
    check("mid_rst_free",  32'(free_slots), 32'd8);
    check("mid_rst_ovf",   32'(overflow),   32'd0);
    check("mid_rst_tid",   32'(tile_id),    32'd0);
    check("mid_rst_rows",  32'(tile_rows),  32'd0);
    tick();
    check("rst_cycle_not_pushed", 32'(out_valid), 32'd0);
    ready = 1'b1;
    drive(1'b1, 20'hB00, 3'd7, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check("post_rst_done", 32'(tile_done), 32'd1);
    check("post_rst_id",   32'(tile_id),   32'd7);
    check("post_rst_rows", 32'(tile_rows), 32'd1);

    // Bad dataflow handling
    ready = 1'b0;
    drive(1'b1, 20'hC00, 3'd1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
`ifdef PE_COLLECTOR_BAD_DATAFLOW_EN
    check("bad_not_stored", 32'(out_valid),  32'd0);
    check("bad_flag_set",   32'(bad_flag),   32'd1);
    check("bad_free",       32'(free_slots), 32'd8);
`else
    check("bad_stored",     32'(out_valid),  32'd1);
    check("bad_d",          32'(out_d),      32'hC00);
    check("bad_flag_clear", 32'(bad_flag),   32'd0);
    check("bad_free",       32'(free_slots), 32'd7);
`endif
    check("bad_no_ovf", 32'(overflow), 32'd0);
    ready = 1'b1;
    tick();
    tick();
    check("bad_drained", 32'(out_valid), 32'd0);

    // Row counter saturation: 260-row tile reports 255
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      drive(1'b1, 20'(k), 3'd2, (k == 259), 1'b0, 1'b0);
      tick();
    end
    idle();
    check("sat_no_pulse_yet", 32'(tile_done), 32'd0);
    tick();
    check("sat_done", 32'(tile_done),  32'd1);
    check("sat_id",   32'(tile_id),    32'd2);
    check("sat_rows", 32'(tile_rows),  32'd255);
    check("sat_free", 32'(free_slots), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
